// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the lap stopwatch.
//   sw_state_t   : stopwatch FSM state encoding
//   SW_MODE_UP   : mode value selecting an up-count
//   SW_MODE_DOWN : mode value selecting a down-count
package stopwatch_pkg;

  typedef enum logic [1:0] {
    SW_IDLE  = 2'd0,
    SW_RUN   = 2'd1,
    SW_PAUSE = 2'd2
  } sw_state_t;

  localparam logic SW_MODE_UP   = 1'b0;
  localparam logic SW_MODE_DOWN = 1'b1;

endpackage

// File: rtl/lap_stopwatch_if.sv
// Lap readout bus between the stopwatch (master) and its consumer (slave).
//   lap_pop      : consumer -> stopwatch, consume the FIFO head
//   lap_valid    : FIFO non-empty
//   lap_data     : FIFO head (first-word-fall-through), 0 when empty
//   lap_level    : FIFO occupancy
//   lap_overflow : sticky, a lap was dropped because the FIFO was full
// Handshake: lap_data is valid whenever lap_valid=1. A pop happens on a
// rising clk edge where lap_pop=1 and lap_valid=1; lap_pop with lap_valid=0
// is ignored. lap_data/lap_valid present the next entry after the pop edge.
interface lap_stopwatch_if #(
  parameter int DATA_WIDTH = 16,
  parameter int LAP_DEPTH  = 4
);
  localparam int LW = $clog2(LAP_DEPTH + 1);

  logic                  lap_pop;
  logic                  lap_valid;
  logic [DATA_WIDTH-1:0] lap_data;
  logic [LW-1:0]         lap_level;
  logic                  lap_overflow;

  modport master (
    input  lap_pop,
    output lap_valid,
    output lap_data,
    output lap_level,
    output lap_overflow
  );

  modport slave (
    output lap_pop,
    input  lap_valid,
    input  lap_data,
    input  lap_level,
    input  lap_overflow
  );
endinterface

// File: rtl/lap_fifo.sv
// Synchronous first-word-fall-through FIFO holding captured lap values.
//   clk, reset : clock, synchronous active-high reset (empties the FIFO)
//   push, din  : write request and data; dropped when full unless a pop
//                happens on the same edge
//   pop        : consume head; ignored when empty
//   dout       : head entry, 0 when empty
//   valid      : non-empty
//   level      : occupancy, 0..DEPTH
//   full       : level == DEPTH
module lap_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4,
  localparam int LW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             valid,
  output logic [LW-1:0]    level,
  output logic             full
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;
  logic             pop_en;
  logic             push_en;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign valid   = (level != '0);
  assign full    = (level == LW'(DEPTH));
  assign pop_en  = pop & valid;
  // A pop on the same edge frees the slot the push needs.
  assign push_en = push & (~full | pop_en);
  assign dout    = valid ? mem[rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (push_en) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      level  <= '0;
    end else begin
      if (push_en) wr_ptr <= ptr_inc(wr_ptr);
      if (pop_en)  rd_ptr <= ptr_inc(rd_ptr);
      case ({push_en, pop_en})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/lap_stopwatch.sv
// Start/stop stopwatch counting 0..MAX up or down, with a one-cycle wrap
// pulse and a lap-capture FIFO read through lap_stopwatch_if.
//   clk, reset : clock, synchronous active-high reset
//   start/stop : control pulses (reset > stop > start)
//   mode       : 0 up, 1 down, sampled every cycle
//   lap        : capture the count visible this cycle into the FIFO
//   count      : current count
//   running    : 1 while in SW_RUN
//   wrap       : pulse coincident with the wrapped (or terminal) count
//   state      : FSM state, exposed for debug
//   lap_bus    : lap FIFO readout (master side)
// Build option STOPWATCH_WRAP_HOLD_EN: an advance onto the terminal value
// (MAX going up, 0 going down) pauses there instead of running on.
module lap_stopwatch
  import stopwatch_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int MAX        = 99,
  parameter int LAP_DEPTH  = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  mode,
  input  logic                  lap,
  output logic [DATA_WIDTH-1:0] count,
  output logic                  running,
  output logic                  wrap,
  output sw_state_t             state,
  lap_stopwatch_if.master       lap_bus
);

  localparam logic [DATA_WIDTH-1:0] MAX_V = DATA_WIDTH'(MAX);

  sw_state_t             state_q;
  sw_state_t             state_d;
  logic [DATA_WIDTH-1:0] count_d;
  logic [DATA_WIDTH-1:0] step_val;
  logic                  wrap_d;
  logic                  advance;
  logic                  at_wrap;
  logic                  overflow_q;
  logic                  fifo_full;
  logic                  fifo_valid;

  always_comb begin
    state_d  = state_q;
    count_d  = count;
    wrap_d   = 1'b0;
    // The start edge itself advances, so count reads 1 right after start.
    advance  = ~stop & (start | (state_q == SW_RUN));
    at_wrap  = (mode == SW_MODE_UP) ? (count == MAX_V) : (count == '0);
    if (mode == SW_MODE_UP) begin
      step_val = at_wrap ? '0 : count + 1'b1;
    end else begin
      step_val = at_wrap ? MAX_V : count - 1'b1;
    end

    case (state_q)
      SW_IDLE, SW_PAUSE: begin
        if (stop)       state_d = SW_PAUSE;
        else if (start) state_d = SW_RUN;
      end
      SW_RUN: begin
        if (stop) state_d = SW_PAUSE;
      end
      default: state_d = SW_IDLE;
    endcase

    if (advance) begin
      count_d = step_val;
      wrap_d  = at_wrap;
`ifdef STOPWATCH_WRAP_HOLD_EN
      // Landing on the terminal value halts and flags it; a later start
      // from there wraps normally.
      if ((mode == SW_MODE_UP) ? (count == MAX_V - 1'b1)
                               : (count == DATA_WIDTH'(1))) begin
        wrap_d  = 1'b1;
        state_d = SW_PAUSE;
      end
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= SW_IDLE;
      count      <= '0;
      wrap       <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q <= state_d;
      count   <= count_d;
      wrap    <= wrap_d;
      if (lap & fifo_full & ~(lap_bus.lap_pop & fifo_valid)) begin
        overflow_q <= 1'b1;
      end
    end
  end

  assign running              = (state_q == SW_RUN);
  assign state                = state_q;
  assign lap_bus.lap_overflow = overflow_q;
  assign lap_bus.lap_valid    = fifo_valid;

  lap_fifo #(
    .WIDTH (DATA_WIDTH),
    .DEPTH (LAP_DEPTH)
  ) u_lap_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (lap),
    .pop   (lap_bus.lap_pop),
    .din   (count),
    .dout  (lap_bus.lap_data),
    .valid (fifo_valid),
    .level (lap_bus.lap_level),
    .full  (fifo_full)
  );

endmodule

// File: tb/tb_lap_stopwatch.sv
module tb_lap_stopwatch;
  import stopwatch_pkg::*;

  localparam int DW = 16;
  localparam int DEPTH = 4;
  localparam int LW = $clog2(DEPTH + 1);

  logic clk = 1'b0;
  logic reset, start, stop, mode, lap;
  logic [DW-1:0] count;
  logic running, wrap;
  sw_state_t state;

  int checks = 0;
  int errors = 0;
  logic [DW-1:0] exp_q[$];
  logic ovf_model;
  int cnt;

  lap_stopwatch_if #(.DATA_WIDTH(DW), .LAP_DEPTH(DEPTH)) bus ();

  lap_stopwatch #(.DATA_WIDTH(DW), .MAX(99), .LAP_DEPTH(DEPTH)) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .stop    (stop),
    .mode    (mode),
    .lap     (lap),
    .count   (count),
    .running (running),
    .wrap    (wrap),
    .state   (state),
    .lap_bus (bus.master)
  );

  // clock
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  // one clock edge, then settle away from the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; start = 1'b0; stop = 1'b0; mode = 1'b0; lap = 1'b0;
    bus.lap_pop = 1'b0;
    tick();
    reset = 1'b0;
  endtask

  task automatic stop_run();
    stop = 1'b1; tick(); stop = 1'b0;
  endtask

  initial begin
    do_reset();
    // reset state
    check("rst_count", 32'(count), 0);
    check("rst_running", 32'(running), 0);
    check("rst_wrap", 32'(wrap), 0);
    check("rst_state", 32'(state), 32'(SW_IDLE));
    check("rst_valid", 32'(bus.lap_valid), 0);
    check("rst_data", 32'(bus.lap_data), 0);
    check("rst_level", 32'(bus.lap_level), 0);
    check("rst_ovf", 32'(bus.lap_overflow), 0);

    // basic run / stop
    start = 1'b1; tick(); start = 1'b0;
    check("run_first", 32'(count), 1);
    check("run_running", 32'(running), 1);
    for (int i = 2; i <= 5; i++) begin
      tick();
      check("run_count", 32'(count), 32'(i));
    end
    stop_run();
    check("stop_hold", 32'(count), 5);
    check("stop_running", 32'(running), 0);
    tick();
    check("stop_hold2", 32'(count), 5);
    start = 1'b1; tick(); start = 1'b0;
    check("resume", 32'(count), 6);
    check("resume_running", 32'(running), 1);
    stop_run();

    // simultaneous start and stop from idle
    do_reset();
    start = 1'b1; stop = 1'b1; tick(); start = 1'b0; stop = 1'b0;
    check("ss_count", 32'(count), 0);
    check("ss_running", 32'(running), 0);
    check("ss_state", 32'(state), 32'(SW_PAUSE));

    // up wrap
    do_reset();
    start = 1'b1; tick(); start = 1'b0;
    for (int i = 0; i < 97; i++) tick();
    check("up_98", 32'(count), 98);
`ifdef STOPWATCH_WRAP_HOLD_EN
    tick();
    check("hold_99", 32'(count), 99);
    check("hold_wrap", 32'(wrap), 1);
    check("hold_running", 32'(running), 0);
    check("hold_state", 32'(state), 32'(SW_PAUSE));
    tick();
    check("hold_stay", 32'(count), 99);
    check("hold_wrap_off", 32'(wrap), 0);
    start = 1'b1; tick(); start = 1'b0;
    check("hold_restart", 32'(count), 0);
    check("hold_restart_wrap", 32'(wrap), 1);
    check("hold_restart_run", 32'(running), 1);
    tick();
    check("hold_after", 32'(count), 1);
    check("hold_after_wrap", 32'(wrap), 0);
`else
    tick();
    check("up_99", 32'(count), 99);
    check("up_99_wrap", 32'(wrap), 0);
    tick();
    check("up_0", 32'(count), 0);
    check("up_0_wrap", 32'(wrap), 1);
    tick();
    check("up_1", 32'(count), 1);
    check("up_1_wrap", 32'(wrap), 0);
`endif
    stop_run();

    // down mode and mid-run direction change
    do_reset();
    mode = 1'b1;
    start = 1'b1; tick(); start = 1'b0;
    check("dn_99", 32'(count), 99);
    check("dn_99_wrap", 32'(wrap), 1);
    tick();
    check("dn_98", 32'(count), 98);
    check("dn_98_wrap", 32'(wrap), 0);
    tick();
    check("dn_97", 32'(count), 97);
    mode = 1'b0;
    tick();
    check("dn_to_up", 32'(count), 98);
    stop_run();

    // laps: fill, full push+pop, overflow, drain
    do_reset();
    exp_q.delete();
    ovf_model = 1'b0;
    start = 1'b1; tick(); start = 1'b0;
    for (cnt = 1; cnt <= 16; cnt++) begin
      lap = (cnt == 3 || cnt == 7 || cnt == 10 || cnt == 12 || cnt == 13 || cnt == 15);
      bus.lap_pop = (cnt == 13);
      if (bus.lap_pop && exp_q.size() > 0) void'(exp_q.pop_front());
      if (lap) begin
        if (exp_q.size() < DEPTH) exp_q.push_back(DW'(cnt));
        else ovf_model = 1'b1;
      end
      tick();
      check("lap_count", 32'(count), 32'(cnt + 1));
      check("lap_level", 32'(bus.lap_level), 32'(exp_q.size()));
      check("lap_ovf", 32'(bus.lap_overflow), 32'(ovf_model));
    end
    lap = 1'b0; bus.lap_pop = 1'b0;
    stop_run();
    check("lap_full_level", 32'(bus.lap_level), 4);
    check("lap_full_ovf", 32'(bus.lap_overflow), 1);
    while (exp_q.size() > 0) begin
      check("pop_valid", 32'(bus.lap_valid), 1);
      check("pop_data", 32'(bus.lap_data), 32'(exp_q.pop_front()));
      bus.lap_pop = 1'b1; tick(); bus.lap_pop = 1'b0;
    end
    check("drain_valid", 32'(bus.lap_valid), 0);
    check("drain_data", 32'(bus.lap_data), 0);
    check("drain_level", 32'(bus.lap_level), 0);
    bus.lap_pop = 1'b1; tick(); bus.lap_pop = 1'b0;
    check("empty_pop_level", 32'(bus.lap_level), 0);
    lap = 1'b1; bus.lap_pop = 1'b1; tick(); lap = 1'b0; bus.lap_pop = 1'b0;
    check("empty_pushpop_level", 32'(bus.lap_level), 1);
    check("empty_pushpop_valid", 32'(bus.lap_valid), 1);
    check("empty_pushpop_data", 32'(bus.lap_data), 17);

    // reset mid-run with laps queued
    do_reset();
    start = 1'b1; tick(); start = 1'b0;
    for (cnt = 1; cnt < 42; cnt++) begin
      lap = (cnt == 10 || cnt == 20);
      tick();
    end
    lap = 1'b0;
    check("mid_count", 32'(count), 42);
    check("mid_level", 32'(bus.lap_level), 2);
    check("mid_head", 32'(bus.lap_data), 10);
    reset = 1'b1; tick(); reset = 1'b0;
    check("mrst_count", 32'(count), 0);
    check("mrst_running", 32'(running), 0);
    check("mrst_level", 32'(bus.lap_level), 0);
    check("mrst_valid", 32'(bus.lap_valid), 0);
    check("mrst_ovf", 32'(bus.lap_overflow), 0);
    check("mrst_wrap", 32'(wrap), 0);
    check("mrst_state", 32'(state), 32'(SW_IDLE));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
